// File: rtl/sequential_adder_controller.sv
`default_nettype none
// ============================================================================
// Module      : sequential_adder_controller (plus carry_lookahead_adder)
// Description : Multi-byte adder that time-multiplexes one 8-bit carry
//               lookahead adder over NUM_BYTES byte slices, LSB first.
//               Requests arrive on a valid/ready handshake and results leave
//               on another.
//               Throughput is one operation every NUM_BYTES+2 cycles.
// Options     : SEQ_ADDER_SUB_EN - when defined, sub_i = 1 computes A-B.
//                                  This is done by inverting B and forcing
//                                  the initial carry to 1.
// Ports       : clk_i, rst_n_i (async, active-low)
//               valid_i/ready_o, a_i, b_i, ci_i, sub_i  - request side
//               valid_o/ready_i, sum_o, co_o, ovf_o     - result side
// Revision    : 1.0 - initial release
// ============================================================================

// 8-bit carry lookahead adder. Each carry is built directly from the
// generate/propagate terms instead of rippling. co_o[i] is the carry out of
// bit i.
module carry_lookahead_adder (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       ci_i,
   output logic [7:0] sum_o,
   output logic [7:0] co_o
);
   logic [7:0] w_p;
   logic [7:0] w_g;

   assign w_p = a_i ^ b_i;
   assign w_g = a_i & b_i;

   always_comb begin
      logic pp;
      co_o = '0;
      for (int i = 0; i < 8; i++) begin
         pp = 1'b1;
         for (int j = i; j >= 0; j--) begin
            co_o[i] = co_o[i] | (pp & w_g[j]);
            pp      = pp & w_p[j];
         end
         co_o[i] = co_o[i] | (pp & ci_i);
      end
   end

   assign sum_o = w_p ^ {co_o[6:0], ci_i};
endmodule

module sequential_adder_controller #(
   parameter int NUM_BYTES = 4            // legal range 2..8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [8*NUM_BYTES-1:0] a_i,
   input  logic [8*NUM_BYTES-1:0] b_i,
   input  logic                   ci_i,
   input  logic                   sub_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [8*NUM_BYTES-1:0] sum_o,
   output logic                   co_o,
   output logic                   ovf_o
);
   localparam int WIDTH = 8 * NUM_BYTES;
   localparam int CNT_W = $clog2(NUM_BYTES);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;        // holds B' (already inverted for subtract)
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] w_b_in;
   logic             w_ci_in;
   logic [7:0]       w_a_byte;
   logic [7:0]       w_b_byte;
   logic [7:0]       w_add_sum;
   logic [7:0]       w_add_co;
   logic             w_unused;

`ifdef SEQ_ADDER_SUB_EN
   // Subtract folds into the captured operand so the datapath stays an adder.
   assign w_b_in   = sub_i ? ~b_i : b_i;
   assign w_ci_in  = sub_i ? 1'b1 : ci_i;
   assign w_unused = ^w_add_co[6:0];
`else
   assign w_b_in   = b_i;
   assign w_ci_in  = ci_i;
   assign w_unused = sub_i ^ (^w_add_co[6:0]);
`endif

   // Select the current byte slice of each operand.
   always_comb begin
      w_a_byte = '0;
      w_b_byte = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            w_a_byte = a_q[i*8 +: 8];
            w_b_byte = b_q[i*8 +: 8];
         end
      end
   end

   carry_lookahead_adder u_cla (
      .a_i   (w_a_byte),
      .b_i   (w_b_byte),
      .ci_i  (carry_q),
      .sum_o (w_add_sum),
      .co_o  (w_add_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_d = RUN;
               a_d     = a_i;
               b_d     = w_b_in;
               carry_d = w_ci_in;
               cnt_d   = '0;
            end
         end
         RUN: begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  sum_d[i*8 +: 8] = w_add_sum;
               end
            end
            carry_d = w_add_co[7];
            if (cnt_q == LAST_BYTE) begin
               // The last slice carries the sign bits, so flags come from here.
               state_d = DONE;
               cnt_d   = '0;
               co_d    = w_add_co[7];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                         (w_add_sum[7] != a_q[WIDTH-1]);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == DONE);
   assign sum_o   = sum_q;
   assign co_o    = co_q;
   assign ovf_o   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_sequential_adder_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequential_adder_controller
// Description : Directed-vector bench for sequential_adder_controller with
//               hand-computed expected values (NUM_BYTES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_adder_controller;
   localparam int NB = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [31:0]   a_i = '0;
   logic [31:0]   b_i = '0;
   logic          ci_i = 1'b0;
   logic          sub_i = 1'b0;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic [31:0]   sum_o;
   logic          co_o;
   logic          ovf_o;

   int n_vec = 0;
   int n_err = 0;

   sequential_adder_controller #(.NUM_BYTES(NB)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .ci_i    (ci_i),
      .sub_i   (sub_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .sum_o   (sum_o),
      .co_o    (co_o),
      .ovf_o   (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Latency is counted with the accept cycle as cycle 1.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub,
                         input logic [31:0] es, input logic eco, input logic eovf);
      int lat;
      @(negedge clk_i);
      check({tag, " ready before"}, 64'(ready_o), 64'd1);
      a_i = a; b_i = b; ci_i = ci; sub_i = sub; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk_i);
      lat = 1;
      @(negedge clk_i);
      valid_i = 1'b0;
      while (!valid_o && lat < 20) begin
         @(posedge clk_i);
         lat++;
         @(negedge clk_i);
      end
      check({tag, " latency"}, 64'(lat), 64'(NB + 1));
      check({tag, " sum"}, 64'(sum_o), 64'(es));
      check({tag, " co"}, 64'(co_o), 64'(eco));
      check({tag, " ovf"}, 64'(ovf_o), 64'(eovf));
      check({tag, " ready in done"}, 64'(ready_o), 64'd0);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check({tag, " valid after xfer"}, 64'(valid_o), 64'd0);
      check({tag, " ready after xfer"}, 64'(ready_o), 64'd1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst ready", 64'(ready_o), 64'd1);
      check("rst valid", 64'(valid_o), 64'd0);
      check("rst sum", 64'(sum_o), 64'd0);
      check("rst co", 64'(co_o), 64'd0);
      check("rst ovf", 64'(ovf_o), 64'd0);
      rst_n_i = 1'b1;

      run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_op("ripple", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0);
      run_op("mixed",  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);
      run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`ifdef SEQ_ADDER_SUB_EN
      run_op("sub",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`else
      run_op("nosub",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
`endif

      // Back-pressure in DONE: result held, inputs ignored.
      begin
         int guard = 0;
         @(negedge clk_i);
         a_i = 32'h0000_0010; b_i = 32'h0000_0020; ci_i = 1'b0; sub_i = 1'b0;
         valid_i = 1'b1;
         @(negedge clk_i);
         valid_i = 1'b0;
         while (!valid_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
         end
         check("hold reach done", 64'(valid_o), 64'd1);
         for (int i = 0; i < 10; i++) begin
            valid_i = ~valid_i;
            a_i = a_i + 32'h0101_0101;
            @(negedge clk_i);
            check("hold sum", 64'(sum_o), 64'h30);
            check("hold ready", 64'(ready_o), 64'd0);
            check("hold valid", 64'(valid_o), 64'd1);
         end
         valid_i = 1'b0;
         ready_i = 1'b1;
         @(negedge clk_i);
         ready_i = 1'b0;
         check("hold release ready", 64'(ready_o), 64'd1);
         @(negedge clk_i);
         check("hold no queued op", 64'(ready_o), 64'd1);
         check("hold no queued valid", 64'(valid_o), 64'd0);
      end

      // Reset two byte cycles into RUN.
      @(negedge clk_i);
      a_i = 32'h0101_0101; b_i = 32'h0101_0101; ci_i = 1'b0; valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("midrun partial sum", 64'(sum_o), 64'h0000_0202);
      rst_n_i = 1'b0;
      #1;
      check("midrst ready", 64'(ready_o), 64'd1);
      check("midrst valid", 64'(valid_o), 64'd0);
      check("midrst sum", 64'(sum_o), 64'd0);
      check("midrst co", 64'(co_o), 64'd0);
      check("midrst ovf", 64'(ovf_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      run_op("postrst", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
